sumsq_control_unit: RTL

Moore controller for the sum-of-squares datapath. It sequences the datapath through a pointer-chased walk of memory pairs: clear, fetch, capture into one of three square slots, reduce pairs into the accumulator, terminate. It drives every enable and mux select of the datapath and observes `A_new`, `B_new` and `Len` from it. Software-side handshake is `start` / `busy` / `done`.

---
 rtl/sumsq_ctrl_pkg.sv | 90 +++++++++
 rtl/sumsq_control_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sumsq_ctrl_pkg.sv
// Shared types and control codes for the sum-of-squares controller:
// state encoding, per-state enable/select constants and the output decoder.
package sumsq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT,
        S_CAPTURE,
        S_RSEL,
        S_RACC,
        S_DONE
    } state_e;

    localparam logic [5:0] P2_SLOT0 = 6'b000011;
    localparam logic [5:0] P2_SLOT1 = 6'b001100;
    localparam logic [5:0] P2_SLOT2 = 6'b110000;

    localparam logic [3:0] S2_PAIR0 = 4'b0000;
    localparam logic [3:0] S2_PAIR1 = 4'b1100;
    localparam logic [3:0] S2_PAIR2 = 4'b0011;

    localparam logic [1:0] P1_EN_CLEAR    = 2'b00;
    localparam logic [1:0] P1_EN_FETCH    = 2'b00;
    localparam logic [1:0] P1_EN_CAPTURE  = 2'b11;
    localparam logic [1:0] S1_SEL_CLEAR   = 2'b00;
    localparam logic [1:0] S1_SEL_FETCH   = 2'b11;
    localparam logic [1:0] S1_SEL_CAPTURE = 2'b00;

    typedef struct packed {
        logic       clear_pipes;
        logic       fireset;
        logic       out_en;
        logic [1:0] p1_en;
        logic [5:0] p2_en;
        logic [1:0] p3_en;
        logic [1:0] s1_sel;
        logic [3:0] s2_sel;
        logic       busy;
        logic       done;
    } ctrl_out_t;

    // Output word for the state about to be entered; slot/pair index pick the masks.
    function automatic ctrl_out_t decode_outputs(input state_e nxt,
                                                 input logic [1:0] slot_idx,
                                                 input logic [1:0] pair_idx);
        ctrl_out_t o;
        o = '0;
        o.busy = (nxt != S_IDLE);
        case (nxt)
            S_CLEAR: begin
                o.clear_pipes = 1'b1;
                o.p1_en       = P1_EN_CLEAR;
                o.s1_sel      = S1_SEL_CLEAR;
            end
            S_FETCH: begin
                o.p1_en  = P1_EN_FETCH;
                o.s1_sel = S1_SEL_FETCH;
            end
            S_CAPTURE: begin
                o.p1_en  = P1_EN_CAPTURE;
                o.s1_sel = S1_SEL_CAPTURE;
                case (slot_idx)
                    2'd0:    o.p2_en = P2_SLOT0;
                    2'd1:    o.p2_en = P2_SLOT1;
                    2'd2:    o.p2_en = P2_SLOT2;
                    default: o.p2_en = '0;
                endcase
            end
            S_RSEL: begin
                o.p3_en = 2'b11;
                case (pair_idx)
                    2'd0:    o.s2_sel = S2_PAIR0;
                    2'd1:    o.s2_sel = S2_PAIR1;
                    2'd2:    o.s2_sel = S2_PAIR2;
                    default: o.s2_sel = '0;
                endcase
            end
            S_RACC: begin
                o.out_en  = 1'b1;
                o.fireset = 1'b1;
            end
            S_DONE:  o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sumsq_control_unit.sv
// Moore controller for the sum-of-squares datapath: walks memory pairs,
// fills up to three square slots, then reduces them into the accumulator.
module sumsq_control_unit
    import sumsq_ctrl_pkg::*;
#(
    parameter logic [8:0] MAX_LEN      = 9'd256,
    parameter logic       STRIDE_A_SEL = 1'b0,
    parameter logic       STRIDE_B_SEL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [8:0] A_new,
    input  logic [8:0] B_new,
    input  logic [8:0] Len,
    output logic       clear_Pipes,
    output logic       fireset,
    output logic       out_En,
    output logic [1:0] p1_En,
    output logic [5:0] p2_En,
    output logic [1:0] p3_En,
    output logic [3:0] s1_Muxes,
    output logic [3:0] s2_Muxes,
    output logic       busy,
    output logic       done
);

    state_e    state;
    ctrl_out_t outs;
    logic [1:0] slot;
    logic [1:0] pairs;
    logic [1:0] rj;
    logic       last;
    logic       armed;

    // Evaluated at 10 bits so Len near 511 cannot wrap past the limit.
    logic [9:0] len_plus2;
    logic       len_hit;
    assign len_plus2 = {1'b0, Len} + 10'd2;
    assign len_hit   = (len_plus2 >= {1'b0, MAX_LEN});

    // The A word carries no control information.
    logic unused_a_new;
    assign unused_a_new = ^A_new;

    // NOTE: every register here uses <=, so all branches see the pre-edge values
    // of state and counters regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            outs  <= '0;
            slot  <= '0;
            pairs <= '0;
            rj    <= '0;
            last  <= 1'b0;
            armed <= 1'b0;
        end else begin
            // start is ignored on the first edge after reset release.
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start && armed) begin
                        state <= S_CLEAR;
                        outs  <= decode_outputs(S_CLEAR, slot, rj);
                    end
                end
                S_CLEAR: begin
                    slot  <= '0;
                    pairs <= '0;
                    last  <= 1'b0;
                    state <= S_FETCH;
                    outs  <= decode_outputs(S_FETCH, slot, rj);
                end
                S_FETCH: begin
                    state <= S_WAIT;
                    outs  <= decode_outputs(S_WAIT, slot, rj);
                end
                S_WAIT: begin
                    if (B_new == '0) begin
                        last <= 1'b1;
                        if (pairs != 2'd0) begin
                            rj    <= '0;
                            state <= S_RSEL;
                            outs  <= decode_outputs(S_RSEL, slot, 2'd0);
                        end else begin
                            state <= S_DONE;
                            outs  <= decode_outputs(S_DONE, slot, rj);
                        end
                    end else begin
                        if (len_hit) last <= 1'b1;
                        state <= S_CAPTURE;
                        outs  <= decode_outputs(S_CAPTURE, slot, rj);
                    end
                end
                S_CAPTURE: begin
                    slot  <= slot + 2'd1;
                    pairs <= pairs + 2'd1;
                    if (pairs == 2'd2 || last) begin
                        rj    <= '0;
                        state <= S_RSEL;
                        outs  <= decode_outputs(S_RSEL, slot, 2'd0);
                    end else begin
                        state <= S_FETCH;
                        outs  <= decode_outputs(S_FETCH, slot, rj);
                    end
                end
                S_RSEL: begin
                    state <= S_RACC;
                    outs  <= decode_outputs(S_RACC, slot, rj);
                end
                S_RACC: begin
                    rj <= rj + 2'd1;
                    if (({1'b0, rj} + 3'd1) < {1'b0, pairs}) begin
                        state <= S_RSEL;
                        outs  <= decode_outputs(S_RSEL, slot, rj + 2'd1);
                    end else if (last) begin
                        state <= S_DONE;
                        outs  <= decode_outputs(S_DONE, slot, rj);
                    end else begin
                        slot  <= '0;
                        pairs <= '0;
                        state <= S_FETCH;
                        outs  <= decode_outputs(S_FETCH, 2'd0, rj);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    outs  <= decode_outputs(S_IDLE, slot, rj);
                end
                default: begin
                    state <= S_IDLE;
                    outs  <= '0;
                end
            endcase
        end
    end

    assign clear_Pipes = outs.clear_pipes;
    assign fireset     = outs.fireset;
    assign out_En      = outs.out_en;
    assign p1_En       = outs.p1_en;
    assign p2_En       = outs.p2_en;
    assign p3_En       = outs.p3_en;
    assign s1_Muxes    = {STRIDE_A_SEL, STRIDE_B_SEL, outs.s1_sel};
    assign s2_Muxes    = outs.s2_sel;
    assign busy        = outs.busy;
    assign done        = outs.done;

endmodule
